// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU request scheduler: opcode encodings, scheduler
// states and default settle latencies.
package fpu_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_OP_WIDTH   = 2;
    localparam int DEFAULT_ADD_CYCLES = 1;
    localparam int DEFAULT_MUL_CYCLES = 2;
    localparam int DEFAULT_DIV_CYCLES = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } sched_state_t;

    function automatic int max_latency(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/fpu_request_scheduler_if.sv
// Signal bundle linking the two requesters, the shared combinational FPU and the
// response consumer to the scheduler.
interface fpu_request_scheduler_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 2
);
    logic                  req0_valid;
    logic                  req0_ready;
    logic [DATA_WIDTH-1:0] req0_operand1;
    logic [DATA_WIDTH-1:0] req0_operand2;
    logic [OP_WIDTH-1:0]   req0_opcode;

    logic                  req1_valid;
    logic                  req1_ready;
    logic [DATA_WIDTH-1:0] req1_operand1;
    logic [DATA_WIDTH-1:0] req1_operand2;
    logic [OP_WIDTH-1:0]   req1_opcode;

    logic [DATA_WIDTH-1:0] fpu_operand1;
    logic [DATA_WIDTH-1:0] fpu_operand2;
    logic [OP_WIDTH-1:0]   fpu_opcode;
    logic [DATA_WIDTH-1:0] fpu_result;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_data;
    logic                  rsp_id;
    logic                  busy;

    // Environment side: requesters, FPU and response consumer.
    modport master (
        output req0_valid, req0_operand1, req0_operand2, req0_opcode,
        output req1_valid, req1_operand1, req1_operand2, req1_opcode,
        output fpu_result, rsp_ready,
        input  req0_ready, req1_ready,
        input  fpu_operand1, fpu_operand2, fpu_opcode,
        input  rsp_valid, rsp_data, rsp_id, busy
    );

    // Scheduler side.
    modport slave (
        input  req0_valid, req0_operand1, req0_operand2, req0_opcode,
        input  req1_valid, req1_operand1, req1_operand2, req1_opcode,
        input  fpu_result, rsp_ready,
        output req0_ready, req1_ready,
        output fpu_operand1, fpu_operand2, fpu_opcode,
        output rsp_valid, rsp_data, rsp_id, busy
    );

endinterface

// File: rtl/fpu_rr_arbiter.sv
// Two-way round-robin grant logic; the priority pointer is owned by the caller,
// and no grant is issued unless advance is high.
module fpu_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       pointer,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant    = 2'b00;
        grant_id = (valid[0] & valid[1]) ? pointer : valid[1];
        if (advance && (valid != 2'b00)) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/fpu_request_scheduler.sv
// Shares one combinational FPU between two requesters: round-robin accept,
// operand hold for an opcode-dependent settle time, then a backpressured response.
module fpu_request_scheduler
    import fpu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int OP_WIDTH   = DEFAULT_OP_WIDTH,
    parameter int ADD_CYCLES = DEFAULT_ADD_CYCLES,
    parameter int MUL_CYCLES = DEFAULT_MUL_CYCLES,
    parameter int DIV_CYCLES = DEFAULT_DIV_CYCLES
) (
    input logic                    clk,
    input logic                    rst,
    fpu_request_scheduler_if.slave bus
);

    localparam int MAX_LAT = max_latency(ADD_CYCLES, MUL_CYCLES, DIV_CYCLES);
    localparam int CNT_W   = $clog2(MAX_LAT) + 1;

    sched_state_t          state;
    sched_state_t          state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  ptr;
    logic                  id_q;
    logic [DATA_WIDTH-1:0] op1_q;
    logic [DATA_WIDTH-1:0] op2_q;
    logic [OP_WIDTH-1:0]   opc_q;
    logic                  rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_id_q;

    logic [1:0]            grant;
    logic                  grant_id;
    logic                  arb_enable;
    logic                  accept;
    logic                  capture;
    logic                  release_rsp;
    logic [DATA_WIDTH-1:0] sel_op1;
    logic [DATA_WIDTH-1:0] sel_op2;
    logic [OP_WIDTH-1:0]   sel_opc;

    function automatic logic [CNT_W-1:0] settle_cycles(input logic [OP_WIDTH-1:0] op);
        case (op)
            OP_ADD, OP_SUB: settle_cycles = CNT_W'(ADD_CYCLES);
            OP_MUL:         settle_cycles = CNT_W'(MUL_CYCLES);
            default:        settle_cycles = CNT_W'(DIV_CYCLES);
        endcase
    endfunction

    // Readies are masked during reset so nothing looks accepted while it is held.
    assign arb_enable = (state == S_IDLE) && !rst;

    fpu_rr_arbiter u_arb (
        .valid    ({bus.req1_valid, bus.req0_valid}),
        .pointer  (ptr),
        .advance  (arb_enable),
        .grant    (grant),
        .grant_id (grant_id)
    );

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        capture     = 1'b0;
        release_rsp = 1'b0;
        sel_op1     = grant_id ? bus.req1_operand1 : bus.req0_operand1;
        sel_op2     = grant_id ? bus.req1_operand2 : bus.req0_operand2;
        sel_opc     = grant_id ? bus.req1_opcode   : bus.req0_opcode;
        case (state)
            S_IDLE: begin
                if (grant != 2'b00) begin
                    accept     = 1'b1;
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                if (cnt == '0) begin
                    capture    = 1'b1;
                    state_next = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    release_rsp = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            ptr         <= 1'b0;
            id_q        <= 1'b0;
            op1_q       <= '0;
            op2_q       <= '0;
            opc_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
        end else begin
            state <= state_next;
            // The FPU inputs only move here, so they are stable through EXEC and RESP.
            if (accept) begin
                op1_q <= sel_op1;
                op2_q <= sel_op2;
                opc_q <= sel_opc;
                id_q  <= grant_id;
                ptr   <= ~grant_id;
                cnt   <= settle_cycles(sel_opc) - CNT_W'(1);
            end else if ((state == S_EXEC) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (capture) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= bus.fpu_result;
                rsp_id_q    <= id_q;
            end else if (release_rsp) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.req0_ready   = grant[0];
    assign bus.req1_ready   = grant[1];
    assign bus.fpu_operand1 = op1_q;
    assign bus.fpu_operand2 = op2_q;
    assign bus.fpu_opcode   = opc_q;
    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.busy         = (state != S_IDLE);

endmodule

// File: tb/tb_fpu_request_scheduler.sv
// Bench for fpu_request_scheduler: a behavioural single-precision FPU stand-in,
// directed vectors, stall/reset sequences and a randomized transaction-level model.
module tb_fpu_request_scheduler;

    localparam int DW      = 32;
    localparam int OW      = 2;
    localparam int ADD_LAT = 1;
    localparam int MUL_LAT = 2;
    localparam int DIV_LAT = 4;

    typedef struct {
        int          sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] exp_data;
        int          lat;
    } vec_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    fpu_request_scheduler_if #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) bus ();

    fpu_request_scheduler #(
        .DATA_WIDTH (DW),
        .OP_WIDTH   (OW),
        .ADD_CYCLES (ADD_LAT),
        .MUL_CYCLES (MUL_LAT),
        .DIV_CYCLES (DIV_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic real sp2real(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:0] == 31'd0) return 0.0;
        d = {x[31], {3'b000, x[30:23]} + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] real2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
        real ra, rb, rr;
        ra = sp2real(a);
        rb = sp2real(b);
        case (op)
            2'b00:   rr = ra + rb;
            2'b01:   rr = ra - rb;
            2'b10:   rr = ra * rb;
            default: rr = (rb == 0.0) ? 0.0 : ra / rb;
        endcase
        return real2sp(rr);
    endfunction

    function automatic int lat_of(input logic [1:0] op);
        if (op == 2'b10) return MUL_LAT;
        if (op == 2'b11) return DIV_LAT;
        return ADD_LAT;
    endfunction

    // The shared FPU is purely combinational.
    assign bus.fpu_result = fp_calc(bus.fpu_operand1, bus.fpu_operand2, bus.fpu_opcode);

    task automatic check_w(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h required=%08h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic check_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [1:0] op);
        if (sel == 0) begin
            bus.req0_valid    = v;
            bus.req0_operand1 = a;
            bus.req0_operand2 = b;
            bus.req0_opcode   = op;
        end else begin
            bus.req1_valid    = v;
            bus.req1_operand1 = a;
            bus.req1_operand2 = b;
            bus.req1_opcode   = op;
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic drain(input string name);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (!bus.busy && !bus.rsp_valid) break;
        end
        check_b({name, "_idle"}, bus.busy, 1'b0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bit busy_ok;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        set_req(v.sel, 1'b1, v.a, v.b, v.op);
        set_req(1 - v.sel, 1'b0, 32'd0, 32'd0, 2'd0);
        @(negedge clk);
        check_b({tag, "_ready"}, (v.sel == 1) ? bus.req1_ready : bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        set_req(v.sel, 1'b0, 32'd0, 32'd0, 2'd0);
        lat     = -1;
        busy_ok = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            busy_ok &= bus.busy;
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
        end
        check_i({tag, "_latency"}, lat, v.lat);
        check_w({tag, "_data"}, bus.rsp_data, v.exp_data);
        check_b({tag, "_id"}, bus.rsp_id, v.sel[0]);
        check_b({tag, "_busy"}, busy_ok, 1'b1);
        @(negedge clk);
        check_b({tag, "_rsp_done"}, bus.rsp_valid, 1'b0);
        check_b({tag, "_back_idle"}, bus.busy, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t        vecs[6];
        int          acc_id[4], acc_cyc[4], rsp_id_seen[4];
        logic [31:0] rsp_dat_seen[4];
        int          n_acc, n_rsp, seen;
        logic [31:0] r_a[2], r_b[2];
        logic [1:0]  r_op[2];
        logic        r_v[2];
        bit          m_busy;
        int          m_left, m_ptr, m_id, g;
        logic [31:0] m_data;

        vecs[0] = '{0, 32'h3F800000, 32'h40000000, 2'b00, 32'h40400000, ADD_LAT};
        vecs[1] = '{1, 32'h40400000, 32'h40000000, 2'b11, 32'h3FC00000, DIV_LAT};
        vecs[2] = '{0, 32'h40400000, 32'h3F800000, 2'b01, 32'h40000000, ADD_LAT};
        vecs[3] = '{1, 32'h40000000, 32'h3FC00000, 2'b10, 32'h40400000, MUL_LAT};
        vecs[4] = '{0, 32'h3F800000, 32'h40000000, 2'b11, 32'h3F000000, DIV_LAT};
        vecs[5] = '{1, 32'h3FC00000, 32'h3FC00000, 2'b00, 32'h40400000, ADD_LAT};

        // Reset held three cycles with both requesters asking.
        rst           = 1'b1;
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'h3F800000, 32'h40000000, 2'b00);
        set_req(1, 1'b1, 32'h40400000, 32'h40000000, 2'b11);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_b("rst_ready0", bus.req0_ready, 1'b0);
            check_b("rst_ready1", bus.req1_ready, 1'b0);
            check_b("rst_rsp_valid", bus.rsp_valid, 1'b0);
            check_b("rst_busy", bus.busy, 1'b0);
        end
        check_w("rst_rsp_data", bus.rsp_data, 32'd0);
        check_b("rst_rsp_id", bus.rsp_id, 1'b0);
        check_w("rst_fpu_op1", bus.fpu_operand1, 32'd0);
        check_w("rst_fpu_op2", bus.fpu_operand2, 32'd0);
        check_w("rst_fpu_opc", {30'd0, bus.fpu_opcode}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(0, 1'b0, 32'd0, 32'd0, 2'd0);
        set_req(1, 1'b0, 32'd0, 32'd0, 2'd0);

        for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Response stalled for several cycles while requester 1 waits.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        set_req(0, 1'b1, 32'h40400000, 32'h40000000, 2'b11);
        @(negedge clk);
        check_b("stall_accept", bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 2'd0);
        set_req(1, 1'b1, 32'h3F800000, 32'h3F800000, 2'b00);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            check_b("stall_valid", bus.rsp_valid, 1'b1);
            check_w("stall_data", bus.rsp_data, 32'h3FC00000);
            check_b("stall_id", bus.rsp_id, 1'b0);
            check_w("stall_fpu_op1", bus.fpu_operand1, 32'h40400000);
            check_w("stall_fpu_op2", bus.fpu_operand2, 32'h40000000);
            check_w("stall_fpu_opc", {30'd0, bus.fpu_opcode}, 32'd3);
            check_b("stall_ready1", bus.req1_ready, 1'b0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_b("stall_release_valid", bus.rsp_valid, 1'b1);
        @(negedge clk);
        check_b("stall_single_xfer", bus.rsp_valid, 1'b0);
        check_b("stall_next_ready", bus.req1_ready, 1'b1);
        @(posedge clk); #1;
        set_req(1, 1'b0, 32'd0, 32'd0, 2'd0);
        @(negedge clk);
        check_b("stall_next_busy", bus.busy, 1'b1);
        check_w("stall_next_op1", bus.fpu_operand1, 32'h3F800000);
        @(negedge clk);
        check_b("stall_next_rsp", bus.rsp_valid, 1'b1);
        check_w("stall_next_data", bus.rsp_data, 32'h40000000);
        check_b("stall_next_id", bus.rsp_id, 1'b1);
        drain("stall_drain");

        // Both requesters contend continuously after reset.
        pulse_reset();
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'h3F800000, 32'h40400000, 2'b10);
        set_req(1, 1'b1, 32'h3F800000, 32'h40400000, 2'b10);
        n_acc = 0;
        n_rsp = 0;
        for (int i = 0; i < 4; i++) begin
            acc_id[i] = -1; acc_cyc[i] = -100; rsp_id_seen[i] = -1; rsp_dat_seen[i] = 32'd0;
        end
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if ((bus.req0_ready || bus.req1_ready) && n_acc < 4) begin
                acc_id[n_acc]  = bus.req1_ready ? 1 : 0;
                acc_cyc[n_acc] = c;
                n_acc++;
            end
            if (bus.rsp_valid && n_rsp < 4) begin
                rsp_id_seen[n_rsp]  = bus.rsp_id ? 1 : 0;
                rsp_dat_seen[n_rsp] = bus.rsp_data;
                n_rsp++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            check_i($sformatf("rr_grant%0d", i), acc_id[i], i % 2);
            check_i($sformatf("rr_rsp_id%0d", i), rsp_id_seen[i], i % 2);
            check_w($sformatf("rr_rsp_data%0d", i), rsp_dat_seen[i], 32'h40400000);
            if (i > 0) check_i($sformatf("rr_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], MUL_LAT + 2);
        end
        drain("rr_drain");

        // Reset in the middle of a multiply drops it.
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        set_req(0, 1'b1, 32'h3F800000, 32'h40400000, 2'b10);
        @(negedge clk);
        check_b("abort_accept", bus.req0_ready, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'd0, 32'd0, 2'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst  = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check_i("abort_no_rsp", seen, 0);
        check_b("abort_idle", bus.busy, 1'b0);
        run_vec('{0, 32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000, ADD_LAT}, "abort_after");

        // Randomized traffic against a transaction-level model.
        pulse_reset();
        m_busy = 1'b0;
        m_left = 0;
        m_ptr  = 0;
        m_id   = 0;
        m_data = 32'd0;
        for (int c = 0; c < 400; c++) begin
            for (int s = 0; s < 2; s++) begin
                r_v[s]  = ($urandom_range(0, 1) == 1);
                r_op[s] = 2'($urandom_range(0, 3));
                r_a[s]  = {1'($urandom_range(0, 1)), 8'($urandom_range(124, 131)), 23'($urandom)};
                r_b[s]  = {1'($urandom_range(0, 1)), 8'($urandom_range(124, 131)), 23'($urandom)};
                set_req(s, r_v[s], r_a[s], r_b[s], r_op[s]);
            end
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            g = -1;
            if (!m_busy) begin
                if (r_v[0] && r_v[1]) g = m_ptr;
                else if (r_v[0])      g = 0;
                else if (r_v[1])      g = 1;
            end
            check_b("rand_ready0", bus.req0_ready, g == 0);
            check_b("rand_ready1", bus.req1_ready, g == 1);
            check_b("rand_busy", bus.busy, m_busy);
            check_b("rand_rsp_valid", bus.rsp_valid, m_busy && m_left == 0);
            if (m_busy && m_left == 0) begin
                check_w("rand_rsp_data", bus.rsp_data, m_data);
                check_b("rand_rsp_id", bus.rsp_id, m_id[0]);
            end
            if (g >= 0) begin
                m_busy = 1'b1;
                m_id   = g;
                m_data = fp_calc(r_a[g], r_b[g], r_op[g]);
                m_left = lat_of(r_op[g]);
                m_ptr  = 1 - g;
            end else if (m_busy && m_left > 0) begin
                m_left--;
            end else if (m_busy && bus.rsp_ready) begin
                m_busy = 1'b0;
            end
            @(posedge clk); #1;
        end
        drain("rand_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
